acc_icb_arbiter: RTL

//  2:1 ICB arbiter inside repvgg_acc_top. It shares the single accelerator memory port (acc_icb_*)

---
 rtl/acc_icb_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/acc_icb_arbiter.sv
// acc_icb_arbiter
//   2:1 ICB arbiter that shares the accelerator memory port between the
//   weight-fetch engine (m0) and the feature-map engine (m1).
//   Command grant is round-robin and is held while a granted command is
//   stalled. An in-order FIFO of issuing IDs routes each response back to
//   the requester that issued the matching command.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mN_icb_cmd_*  (N=0,1)         requester command channel (valid/ready/read/addr/wdata/wmask)
//   mN_icb_rsp_*                  routed response channel (valid/ready/err/rdata)
//   acc_icb_cmd_*                 muxed command to memory
//   acc_icb_rsp_*                 memory response
//   outs_cnt                      registered count of outstanding commands
//   unexp_rsp                     sticky flag: response seen with nothing outstanding
module acc_icb_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int OUTS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         m0_icb_cmd_valid,
   output logic                         m0_icb_cmd_ready,
   input  logic                         m0_icb_cmd_read,
   input  logic [ADDR_W-1:0]            m0_icb_cmd_addr,
   input  logic [DATA_W-1:0]            m0_icb_cmd_wdata,
   input  logic [DATA_W/8-1:0]          m0_icb_cmd_wmask,
   output logic                         m0_icb_rsp_valid,
   input  logic                         m0_icb_rsp_ready,
   output logic                         m0_icb_rsp_err,
   output logic [DATA_W-1:0]            m0_icb_rsp_rdata,
   input  logic                         m1_icb_cmd_valid,
   output logic                         m1_icb_cmd_ready,
   input  logic                         m1_icb_cmd_read,
   input  logic [ADDR_W-1:0]            m1_icb_cmd_addr,
   input  logic [DATA_W-1:0]            m1_icb_cmd_wdata,
   input  logic [DATA_W/8-1:0]          m1_icb_cmd_wmask,
   output logic                         m1_icb_rsp_valid,
   input  logic                         m1_icb_rsp_ready,
   output logic                         m1_icb_rsp_err,
   output logic [DATA_W-1:0]            m1_icb_rsp_rdata,
   output logic                         acc_icb_cmd_valid,
   input  logic                         acc_icb_cmd_ready,
   output logic                         acc_icb_cmd_read,
   output logic [ADDR_W-1:0]            acc_icb_cmd_addr,
   output logic [DATA_W-1:0]            acc_icb_cmd_wdata,
   output logic [DATA_W/8-1:0]          acc_icb_cmd_wmask,
   input  logic                         acc_icb_rsp_valid,
   output logic                         acc_icb_rsp_ready,
   input  logic                         acc_icb_rsp_err,
   input  logic [DATA_W-1:0]            acc_icb_rsp_rdata,
   output logic [$clog2(OUTS_DEPTH):0]  outs_cnt,
   output logic                         unexp_rsp
);

   localparam int PW = $clog2(OUTS_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {ARB_FREE, ARB_HOLD} arb_state_e;

   arb_state_e           state_q, state_d;
   logic                 last_gnt_q;
   logic                 rr_ptr_q;
   logic [OUTS_DEPTH-1:0] ids_q;
   logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 unexp_q;

   logic gnt;
   logic gnt_valid;
   logic fifo_full;
   logic fifo_empty;
   logic cmd_hs;
   logic head;
   logic push, pop;

   assign fifo_full  = (cnt_q == CW'(OUTS_DEPTH));
   assign fifo_empty = (cnt_q == '0);
   assign head       = ids_q[rd_ptr_q];

   // ---------------- grant FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_FREE;
         last_gnt_q <= 1'b0;
         rr_ptr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= gnt;
         if (cmd_hs) rr_ptr_q <= ~gnt;
      end
   end

   // ---------------- grant FSM: next state ----------------
   // HOLD whenever the granted requester is presenting a command that did
   // not complete, so the grant cannot move away from a pending command.
   always_comb begin
      state_d = ARB_FREE;
      if (gnt_valid && !cmd_hs) state_d = ARB_HOLD;
   end

   // ---------------- grant FSM: outputs ----------------
   always_comb begin
      gnt = 1'b0;
      if (state_q == ARB_HOLD)                          gnt = last_gnt_q;
      else if (m0_icb_cmd_valid && m1_icb_cmd_valid)    gnt = rr_ptr_q;
      else if (m1_icb_cmd_valid)                        gnt = 1'b1;
      gnt_valid = gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;
   end

   // ---------------- command mux ----------------
   assign acc_icb_cmd_valid = gnt_valid & ~fifo_full;
   assign acc_icb_cmd_read  = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
   assign acc_icb_cmd_addr  = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
   assign acc_icb_cmd_wdata = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
   assign acc_icb_cmd_wmask = gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
   assign m0_icb_cmd_ready  = ~gnt & acc_icb_cmd_ready & ~fifo_full;
   assign m1_icb_cmd_ready  =  gnt & acc_icb_cmd_ready & ~fifo_full;
   assign cmd_hs            = acc_icb_cmd_valid & acc_icb_cmd_ready;

   // ---------------- response routing ----------------
   assign m0_icb_rsp_valid  = acc_icb_rsp_valid & ~fifo_empty & ~head;
   assign m1_icb_rsp_valid  = acc_icb_rsp_valid & ~fifo_empty &  head;
   assign m0_icb_rsp_err    = acc_icb_rsp_err;
   assign m1_icb_rsp_err    = acc_icb_rsp_err;
   assign m0_icb_rsp_rdata  = acc_icb_rsp_rdata;
   assign m1_icb_rsp_rdata  = acc_icb_rsp_rdata;
   // With nothing outstanding a response is accepted and dropped so the
   // memory side cannot wedge on a stray response.
   assign acc_icb_rsp_ready = fifo_empty ? acc_icb_rsp_valid
                                         : (head ? m1_icb_rsp_ready : m0_icb_rsp_ready);

   // ---------------- outstanding-ID FIFO ----------------
   // Push is gated by the registered full flag, so push+pop at full never
   // happens; push+pop below full leaves the count unchanged.
   assign push = cmd_hs;
   assign pop  = acc_icb_rsp_valid & acc_icb_rsp_ready & ~fifo_empty;

   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         unexp_q  <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q <= cnt_d;
         if (acc_icb_rsp_valid && fifo_empty) unexp_q <= 1'b1;
      end
   end

   // ID storage needs no reset: entries are only read once written.
   always_ff @(posedge clk) begin
      if (push) ids_q[wr_ptr_q] <= gnt;
   end

   assign outs_cnt  = cnt_q;
   assign unexp_rsp = unexp_q;

endmodule
